rv32v_memory_stage: RTL and testbench

RV32V_MEMORY_STAGE -- requirements
Module: rv32v_memory_stage

---
 rtl/rv32v_memory_stage.sv | 153 +++++++++++++++
 tb/tb_rv32v_memory_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_memory_stage.sv
// Vector memory stage: walks two 32-bit element lanes through the data bus and feeds the writeback latch.
// Optional build macro RV32V_MEM_SKIP_MASKED_EN skips lanes whose wen0/wen1 is low.
`timescale 1ns/1ps
module rv32v_memory_stage #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load,
  input  logic              store,
  input  logic              config_type,
  input  logic [DATA_W-1:0] aluresult0,
  input  logic [DATA_W-1:0] aluresult1,
  input  logic [DATA_W-1:0] storedata0,
  input  logic [DATA_W-1:0] storedata1,
  input  logic [31:0]       vl,
  input  logic              wen0,
  input  logic              wen1,
  input  logic [4:0]        woffset0,
  input  logic [4:0]        woffset1,
  input  logic [7:0]        vtype,
  input  logic              flush_mem,
  input  logic              stall_mem,
  output logic              busy_mem,
  output logic              dmem_ren,
  output logic              dmem_wen,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_busy,
  output logic              wb_wen0,
  output logic              wb_wen1,
  output logic [4:0]        wb_woffset0,
  output logic [4:0]        wb_woffset1,
  output logic [DATA_W-1:0] wb_wdata0,
  output logic [DATA_W-1:0] wb_wdata1,
  output logic              wb_config_type,
  output logic [31:0]       wb_vl,
  output logic [7:0]        wb_vtype
);

`ifdef RV32V_MEM_SKIP_MASKED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LANE0, LANE1, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data0_q, data1_q;
  logic [DATA_W-1:0] rd0, rd1;
  logic              mem_op, in_lane, lane_wen, req_raw, lane_done, last_done, wb_upd;

  assign mem_op   = load | store;
  assign in_lane  = (state == LANE0) || (state == LANE1);
  assign lane_wen = (state == LANE1) ? wen1 : wen0;
  // An inactive store lane issues nothing; inactive load lanes still read unless skipping.
  assign req_raw   = in_lane & mem_op & (load | lane_wen);
  assign lane_done = !req_raw | !dmem_busy;

  assign dmem_ren   = req_raw & load & !flush_mem;
  assign dmem_wen   = req_raw & store & !load & !flush_mem;
  assign dmem_addr  = (state == LANE1) ? aluresult1 : aluresult0;
  assign dmem_wdata = (state == LANE1) ? storedata1 : storedata0;

  always_comb begin
    last_done = 1'b0;
    case (state)
      IDLE:    last_done = SKIP & !wen0 & !wen1;
      LANE0:   last_done = SKIP & !wen1 & lane_done;
      LANE1:   last_done = lane_done;
      default: last_done = 1'b1;
    endcase
  end

  assign busy_mem = mem_op & !last_done;
  assign wb_upd   = !busy_mem & !stall_mem & !flush_mem;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (mem_op) begin
          if (SKIP && !wen0) state_nxt = wen1 ? LANE1 : IDLE;
          else               state_nxt = LANE0;
        end
      LANE0:
        if (lane_done) begin
          if (SKIP && !wen1) state_nxt = stall_mem ? DONE : IDLE;
          else               state_nxt = LANE1;
        end
      LANE1:
        if (lane_done) state_nxt = stall_mem ? DONE : IDLE;
      default:
        if (!stall_mem) state_nxt = IDLE;
    endcase
    if (flush_mem) state_nxt = IDLE;
  end

  // Read data comes straight off the bus in the completing lane, otherwise from the buffers.
  assign rd0 = (state == LANE0) ? dmem_rdata : data0_q;
  assign rd1 = (state == LANE1) ? dmem_rdata : data1_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state          <= IDLE;
      data0_q        <= '0;
      data1_q        <= '0;
      wb_wen0        <= 1'b0;
      wb_wen1        <= 1'b0;
      wb_woffset0    <= '0;
      wb_woffset1    <= '0;
      wb_wdata0      <= '0;
      wb_wdata1      <= '0;
      wb_config_type <= 1'b0;
      wb_vl          <= '0;
      wb_vtype       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && mem_op) begin
        data0_q <= '0;
        data1_q <= '0;
      end
      if (dmem_ren && !dmem_busy) begin
        if (state == LANE0) data0_q <= dmem_rdata;
        else                data1_q <= dmem_rdata;
      end
      if (flush_mem) begin
        wb_wen0        <= 1'b0;
        wb_wen1        <= 1'b0;
        wb_woffset0    <= '0;
        wb_woffset1    <= '0;
        wb_wdata0      <= '0;
        wb_wdata1      <= '0;
        wb_config_type <= 1'b0;
        wb_vl          <= '0;
        wb_vtype       <= '0;
      end else if (wb_upd) begin
        wb_wen0        <= wen0 & !store;
        wb_wen1        <= wen1 & !store;
        wb_woffset0    <= woffset0;
        wb_woffset1    <= woffset1;
        wb_wdata0      <= load ? rd0 : aluresult0;
        wb_wdata1      <= load ? rd1 : aluresult1;
        wb_config_type <= config_type;
        wb_vl          <= vl;
        wb_vtype       <= vtype;
      end
    end
  end

endmodule

// File: tb/tb_rv32v_memory_stage.sv
// Directed bench for rv32v_memory_stage: ALU-op vector table plus hand-written memory sequences.
`timescale 1ns/1ps
module tb_rv32v_memory_stage;

  logic        CLK, nRST;
  logic        load, store, config_type;
  logic [31:0] aluresult0, aluresult1, storedata0, storedata1, vl;
  logic        wen0, wen1;
  logic [4:0]  woffset0, woffset1;
  logic [7:0]  vtype;
  logic        flush_mem, stall_mem, busy_mem;
  logic        dmem_ren, dmem_wen, dmem_busy;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_wen0, wb_wen1, wb_config_type;
  logic [4:0]  wb_woffset0, wb_woffset1;
  logic [31:0] wb_wdata0, wb_wdata1, wb_vl;
  logic [7:0]  wb_vtype;

  rv32v_memory_stage dut (
    .CLK(CLK), .nRST(nRST),
    .load(load), .store(store), .config_type(config_type),
    .aluresult0(aluresult0), .aluresult1(aluresult1),
    .storedata0(storedata0), .storedata1(storedata1), .vl(vl),
    .wen0(wen0), .wen1(wen1), .woffset0(woffset0), .woffset1(woffset1), .vtype(vtype),
    .flush_mem(flush_mem), .stall_mem(stall_mem), .busy_mem(busy_mem),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_busy(dmem_busy),
    .wb_wen0(wb_wen0), .wb_wen1(wb_wen1), .wb_woffset0(wb_woffset0), .wb_woffset1(wb_woffset1),
    .wb_wdata0(wb_wdata0), .wb_wdata1(wb_wdata1), .wb_config_type(wb_config_type),
    .wb_vl(wb_vl), .wb_vtype(wb_vtype)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always_comb begin
    if (dmem_addr == 32'h100)      dmem_rdata = 32'h0000_AAAA;
    else if (dmem_addr == 32'h104) dmem_rdata = 32'h0000_BBBB;
    else                           dmem_rdata = 32'hDEAD_0000 | dmem_addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;

  typedef struct {
    logic w;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;
  xfer_t log_q[$];

  typedef struct {
    logic [31:0] a0, a1;
    logic        w0, w1;
    logic [4:0]  o0, o1;
    logic        ct;
    logic [31:0] v_l;
    logic [7:0]  v_t;
    logic        stl, fl;
    logic [31:0] e0, e1;
    logic        ew0, ew1;
    logic [4:0]  eo0, eo1;
    logic        ect;
    logic [31:0] evl;
    logic [7:0]  evt;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] s0, input logic [31:0] s1, input logic w0, input logic w1);
    load = ld; store = st;
    aluresult0 = a0; aluresult1 = a1;
    storedata0 = s0; storedata1 = s1;
    wen0 = w0; wen1 = w1;
  endtask

  // Runs one memory op to completion; waits = dmem_busy cycles inserted before each transfer.
  task automatic run_op(input int waits, output int busy_cyc);
    int wl;
    bit fin;
    wl = waits; busy_cyc = 0; fin = 1'b0;
    log_q.delete();
    for (int c = 0; c < 40 && !fin; c++) begin
      #1;
      dmem_busy = (dmem_ren | dmem_wen) && (wl > 0);
      #1;
      chk("ren_wen_excl", {31'b0, dmem_ren & dmem_wen}, 32'd0);
      if (busy_mem) busy_cyc++;
      if ((dmem_ren | dmem_wen) && !dmem_busy) begin
        log_q.push_back(xfer_t'{dmem_wen, dmem_addr, dmem_wdata});
        wl = waits;
      end else if (dmem_busy) begin
        wl--;
      end
      if (!busy_mem) fin = 1'b1;
      @(posedge CLK);
    end
    #1;
    dmem_busy = 1'b0;
    load = 1'b0;
    store = 1'b0;
    chk("op_timeout", {31'b0, fin}, 32'd1);
  endtask

  initial begin
    int bc;
    vecs[0] = '{32'd5, 32'd7, 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 32'd4, 8'h10, 1'b0, 1'b0,
                32'd5, 32'd7, 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 32'd4, 8'h10};
    vecs[1] = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 5'd31, 5'd0, 1'b1, 32'd32, 8'hD3, 1'b0, 1'b0,
                32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 5'd31, 5'd0, 1'b1, 32'd32, 8'hD3};
    vecs[2] = '{32'h1111, 32'h2222, 1'b0, 1'b0, 5'd3, 5'd4, 1'b0, 32'd1, 8'h01, 1'b1, 1'b0,
                32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 5'd31, 5'd0, 1'b1, 32'd32, 8'hD3};
    vecs[3] = '{32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0, 1'b1, 5'd7, 5'd8, 1'b1, 32'd16, 8'h5A, 1'b0, 1'b0,
                32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0, 1'b1, 5'd7, 5'd8, 1'b1, 32'd16, 8'h5A};
    vecs[4] = '{32'd9, 32'd9, 1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 32'd9, 8'h09, 1'b0, 1'b1,
                32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'd0, 8'h00};
    vecs[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 5'd30, 5'd15, 1'b1, 32'h80, 8'hC0, 1'b0, 1'b0,
                32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 5'd30, 5'd15, 1'b1, 32'h80, 8'hC0};

    nRST = 1'b0;
    set_op(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    config_type = 1'b0; vl = 32'd0; vtype = 8'd0; woffset0 = 5'd0; woffset1 = 5'd0;
    flush_mem = 1'b0; stall_mem = 1'b0; dmem_busy = 1'b0;
    #2;
    chk("rst_wb_wdata0", wb_wdata0, 32'd0);
    chk("rst_wb_wdata1", wb_wdata1, 32'd0);
    chk("rst_wb_wen", {30'b0, wb_wen0, wb_wen1}, 32'd0);
    chk("rst_wb_vl", wb_vl, 32'd0);
    chk("rst_busy", {31'b0, busy_mem}, 32'd0);
    chk("rst_req", {30'b0, dmem_ren, dmem_wen}, 32'd0);
    tick();
    tick();
    nRST = 1'b1;

    // Single-cycle ALU ops, stall hold and flush clear through the writeback latch.
    for (int i = 0; i < 6; i++) begin
      set_op(1'b0, 1'b0, vecs[i].a0, vecs[i].a1, 32'd0, 32'd0, vecs[i].w0, vecs[i].w1);
      woffset0 = vecs[i].o0; woffset1 = vecs[i].o1; config_type = vecs[i].ct;
      vl = vecs[i].v_l; vtype = vecs[i].v_t; stall_mem = vecs[i].stl; flush_mem = vecs[i].fl;
      #1;
      chk($sformatf("v%0d_busy", i), {31'b0, busy_mem}, 32'd0);
      chk($sformatf("v%0d_req", i), {30'b0, dmem_ren, dmem_wen}, 32'd0);
      tick();
      stall_mem = 1'b0; flush_mem = 1'b0;
      chk($sformatf("v%0d_wdata0", i), wb_wdata0, vecs[i].e0);
      chk($sformatf("v%0d_wdata1", i), wb_wdata1, vecs[i].e1);
      chk($sformatf("v%0d_wen", i), {30'b0, wb_wen0, wb_wen1}, {30'b0, vecs[i].ew0, vecs[i].ew1});
      chk($sformatf("v%0d_woff", i), {22'b0, wb_woffset0, wb_woffset1}, {22'b0, vecs[i].eo0, vecs[i].eo1});
      chk($sformatf("v%0d_ct", i), {31'b0, wb_config_type}, {31'b0, vecs[i].ect});
      chk($sformatf("v%0d_vl", i), wb_vl, vecs[i].evl);
      chk($sformatf("v%0d_vtype", i), {24'b0, wb_vtype}, {24'b0, vecs[i].evt});
    end

    // Zero-wait two-lane load.
    set_op(1'b1, 1'b0, 32'h100, 32'h104, 32'd0, 32'd0, 1'b1, 1'b1);
    run_op(0, bc);
    chk("ld_busy_cycles", bc, 32'd2);
    chk("ld_xfers", log_q.size(), 32'd2);
    if (log_q.size() == 2) begin
      chk("ld_x0", {log_q[0].w, log_q[0].a[30:0]}, {1'b0, 31'h100});
      chk("ld_x1", {log_q[1].w, log_q[1].a[30:0]}, {1'b0, 31'h104});
    end
    chk("ld_wdata0", wb_wdata0, 32'hAAAA);
    chk("ld_wdata1", wb_wdata1, 32'hBBBB);
    chk("ld_wen", {30'b0, wb_wen0, wb_wen1}, 32'd3);

    // Store with two wait cycles per lane.
    set_op(1'b0, 1'b1, 32'h100, 32'h104, 32'h11, 32'h22, 1'b1, 1'b1);
    run_op(2, bc);
    chk("st_busy_cycles", bc, 32'd6);
    chk("st_xfers", log_q.size(), 32'd2);
    if (log_q.size() == 2) begin
      chk("st_x0_addr", log_q[0].a, 32'h100);
      chk("st_x0_data", log_q[0].d, 32'h11);
      chk("st_x1_addr", log_q[1].a, 32'h104);
      chk("st_x1_data", log_q[1].d, 32'h22);
      chk("st_x_write", {30'b0, log_q[0].w, log_q[1].w}, 32'd3);
    end
    chk("st_wen", {30'b0, wb_wen0, wb_wen1}, 32'd0);

`ifdef RV32V_MEM_SKIP_MASKED_EN
    // Lane 0 inactive: only lane 1 is read, lane 0 buffer reads back as zero.
    set_op(1'b1, 1'b0, 32'h100, 32'h104, 32'd0, 32'd0, 1'b0, 1'b1);
    run_op(0, bc);
    chk("skip_busy_cycles", bc, 32'd1);
    chk("skip_xfers", log_q.size(), 32'd1);
    if (log_q.size() == 1) chk("skip_x0_addr", log_q[0].a, 32'h104);
    chk("skip_wen", {30'b0, wb_wen0, wb_wen1}, 32'd1);
    chk("skip_wdata0", wb_wdata0, 32'd0);
    chk("skip_wdata1", wb_wdata1, 32'hBBBB);
`else
    // Lane 0 inactive: load still reads both lanes, store idles lane 0 for one cycle.
    set_op(1'b1, 1'b0, 32'h100, 32'h104, 32'd0, 32'd0, 1'b0, 1'b1);
    run_op(0, bc);
    chk("inact_ld_busy", bc, 32'd2);
    chk("inact_ld_xfers", log_q.size(), 32'd2);
    chk("inact_ld_wen", {30'b0, wb_wen0, wb_wen1}, 32'd1);
    chk("inact_ld_wdata1", wb_wdata1, 32'hBBBB);
    set_op(1'b0, 1'b1, 32'h100, 32'h104, 32'h11, 32'h22, 1'b0, 1'b1);
    run_op(0, bc);
    chk("inact_st_busy", bc, 32'd2);
    chk("inact_st_xfers", log_q.size(), 32'd1);
    if (log_q.size() == 1) chk("inact_st_data", log_q[0].d, 32'h22);
`endif

    // Stall at lane 1 completion parks the FSM in DONE.
    set_op(1'b0, 1'b0, 32'h77, 32'h88, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    set_op(1'b1, 1'b0, 32'h104, 32'h100, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    tick();
    stall_mem = 1'b1;
    #1;
    chk("stl_l1_ren", {31'b0, dmem_ren}, 32'd1);
    chk("stl_l1_busy", {31'b0, busy_mem}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) stall_mem = 1'b0;
      #1;
      chk($sformatf("stl_done%0d_req", i), {30'b0, dmem_ren, dmem_wen}, 32'd0);
      chk($sformatf("stl_done%0d_busy", i), {31'b0, busy_mem}, 32'd0);
      chk($sformatf("stl_done%0d_hold", i), wb_wdata0, 32'h77);
    end
    tick();
    load = 1'b0;
    chk("stl_wdata0", wb_wdata0, 32'hBBBB);
    chk("stl_wdata1", wb_wdata1, 32'hAAAA);

    // Flush while lane 1 waits on the bus.
    set_op(1'b0, 1'b0, 32'h33, 32'h44, 32'd0, 32'd0, 1'b1, 1'b1);
    vl = 32'd5; vtype = 8'h03;
    tick();
    set_op(1'b1, 1'b0, 32'h100, 32'h104, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    tick();
    dmem_busy = 1'b1;
    #1;
    chk("fl_pre_ren", {31'b0, dmem_ren}, 32'd1);
    flush_mem = 1'b1;
    #1;
    chk("fl_req_drop", {30'b0, dmem_ren, dmem_wen}, 32'd0);
    tick();
    flush_mem = 1'b0;
    #1;
    chk("fl_idle", {30'b0, dmem_ren, busy_mem}, 32'd1);
    load = 1'b0; dmem_busy = 1'b0;
    chk("fl_wdata", wb_wdata0 | wb_wdata1, 32'd0);
    chk("fl_wen", {30'b0, wb_wen0, wb_wen1}, 32'd0);
    chk("fl_vl_vtype", wb_vl | {24'b0, wb_vtype}, 32'd0);

    // Asynchronous reset in the middle of a store.
    set_op(1'b0, 1'b0, 32'h55, 32'h66, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    set_op(1'b0, 1'b1, 32'h100, 32'h104, 32'h11, 32'h22, 1'b1, 1'b1);
    dmem_busy = 1'b1;
    tick();
    chk("rm_pre_wen", {31'b0, dmem_wen}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("rm_req", {30'b0, dmem_ren, dmem_wen}, 32'd0);
    chk("rm_wdata0", wb_wdata0, 32'd0);
    store = 1'b0; dmem_busy = 1'b0;
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("rm_after%0d", i), {29'b0, dmem_ren, dmem_wen, busy_mem}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
